// File: rtl/disp_scan.sv
// Four-digit multiplexed display scanner: show/guard time slicing per digit,
// double-buffered display data swapped at frame boundaries, leading-zero blanking.
module disp_scan #(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  output logic [1:0]  digit,
  output logic [3:0]  nibble,
  output logic        dp,
  output logic        blank,
  output logic        pending,
  output logic        frame_tick
);

  localparam int unsigned CMAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int unsigned CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic          NO_GUARD   = (BLANK_CYC == 0);

  typedef enum logic {SHOW, GUARD} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]  dig, dig_nxt;
  logic        xfer;

  logic [15:0] shadow_v, act_v;
  logic [3:0]  shadow_dp, act_dp;
  logic        pend;
  logic        hi_zero;
  logic        dp_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SHOW;
      cnt   <= '0;
      dig   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dig   <= dig_nxt;
    end
  end

  // xfer marks the final cycle of digit 3, whichever phase that ends in
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    dig_nxt   = dig;
    xfer      = 1'b0;
    case (state)
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_nxt = '0;
          if (NO_GUARD) begin
            dig_nxt = dig + 2'd1;
            xfer    = (dig == 2'd3);
          end else begin
            state_nxt = GUARD;
          end
        end
      end
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = SHOW;
          dig_nxt   = dig + 2'd1;
          xfer      = (dig == 2'd3);
        end
      end
      default: state_nxt = SHOW;
    endcase
  end

  // A load on the transfer edge wins over the pending clear; active takes the old shadow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_v  <= '0;
      shadow_dp <= '0;
      act_v     <= '0;
      act_dp    <= '0;
      pend      <= 1'b0;
    end else begin
      if (xfer && pend) begin
        act_v  <= shadow_v;
        act_dp <= shadow_dp;
      end
      if (load) begin
        shadow_v  <= value;
        shadow_dp <= dp_in;
        pend      <= 1'b1;
      end else if (xfer) begin
        pend <= 1'b0;
      end
    end
  end

  always_comb begin
    hi_zero = 1'b0;
    case (dig)
      2'd1:    hi_zero = (act_v[15:4]  == '0);
      2'd2:    hi_zero = (act_v[15:8]  == '0);
      2'd3:    hi_zero = (act_v[15:12] == '0);
      default: hi_zero = 1'b0;
    endcase
    dp_bit     = act_dp[dig];
    digit      = dig;
    nibble     = act_v[4*dig +: 4];
    dp         = dp_bit;
    pending    = pend;
    blank      = (state == GUARD) | (lz_blank & hi_zero & ~dp_bit);
    // Reset leaves the FSM at the frame-start position; gate so the tick stays low while held
    frame_tick = reset_n & (state == SHOW) & (cnt == '0) & (dig == 2'd0);
  end

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with CLK_DIV=4, BLANK_CYC=2; a frame-position
// reference model queues expected outputs each cycle and they are checked mid-cycle.
module tb_disp_scan;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [1:0]  digit;
  logic [3:0]  nibble;
  logic        dp, blank, pending, frame_tick;

  disp_scan #(.CLK_DIV(4), .BLANK_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .value(value), .dp_in(dp_in),
    .lz_blank(lz_blank), .digit(digit), .nibble(nibble), .dp(dp), .blank(blank),
    .pending(pending), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] dg;
    logic [3:0] nib;
    logic       dpo;
    logic       blk;
    logic       pnd;
    logic       tick;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // model: position within a 24-cycle frame plus the two data buffers
  int          t;
  logic [15:0] m_sh, m_act;
  logic [3:0]  m_sh_dp, m_act_dp;
  logic        m_pend;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, expv, t);
    end
  endtask

  task automatic model_reset();
    t = 0; m_sh = '0; m_act = '0; m_sh_dp = '0; m_act_dp = '0; m_pend = 1'b0;
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic cyc(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic lz);
    exp_t e;
    int   dg;
    logic guard;
    load = ld; value = v; dp_in = d; lz_blank = lz;
    dg    = t / 6;
    guard = (t % 6) >= 4;
    e.dg   = 2'(dg);
    e.nib  = 4'((m_act >> (4 * dg)) & 16'hF);
    e.dpo  = m_act_dp[dg];
    e.blk  = guard | (lz && !guard && dg != 0 && !m_act_dp[dg] && ((m_act >> (4 * dg)) == 16'h0));
    e.pnd  = m_pend;
    e.tick = (t == 0);
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    chk("digit",      16'(digit),      16'(e.dg));
    chk("nibble",     16'(nibble),     16'(e.nib));
    chk("dp",         16'(dp),         16'(e.dpo));
    chk("blank",      16'(blank),      16'(e.blk));
    chk("pending",    16'(pending),    16'(e.pnd));
    chk("frame_tick", 16'(frame_tick), 16'(e.tick));
    @(posedge clk);
    if (t == 23 && m_pend) begin
      m_act = m_sh; m_act_dp = m_sh_dp; m_pend = 1'b0;
    end
    if (ld) begin
      m_sh = v; m_sh_dp = d; m_pend = 1'b1;
    end
    t = (t + 1) % 24;
    #1;
    load = 1'b0;
  endtask

  task automatic idle(input int n, input logic lz);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 4'h0, lz);
  endtask

  task automatic run_to(input int target, input logic lz);
    for (int i = 0; i < 24 && t != target; i++) cyc(1'b0, 16'h0, 4'h0, lz);
  endtask

  task automatic check_reset_outputs();
    chk("rst_digit",  16'(digit),      16'h0);
    chk("rst_nibble", 16'(nibble),     16'h0);
    chk("rst_dp",     16'(dp),         16'h0);
    chk("rst_blank",  16'(blank),      16'h0);
    chk("rst_pend",   16'(pending),    16'h0);
    chk("rst_tick",   16'(frame_tick), 16'h0);
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; lz_blank = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset_n = 1'b1;

    // free run, no data
    idle(24, 1'b0);

    // load mid digit 1, shown from the next frame start
    run_to(8, 1'b0);
    cyc(1'b1, 16'h1234, 4'h0, 1'b0);
    run_to(0, 1'b0);
    idle(24, 1'b0);

    // two loads before the swap: only the second is ever shown
    run_to(3, 1'b0);
    cyc(1'b1, 16'hAAAA, 4'hF, 1'b0);
    idle(5, 1'b0);
    cyc(1'b1, 16'h00F0, 4'h1, 1'b0);
    run_to(0, 1'b0);
    idle(24, 1'b0);

    // load exactly on the transfer cycle
    run_to(2, 1'b0);
    cyc(1'b1, 16'h5678, 4'h2, 1'b0);
    run_to(23, 1'b0);
    cyc(1'b1, 16'h9ABC, 4'h8, 1'b0);
    idle(48, 1'b0);

    // leading-zero blanking, then a dp bit overriding it on digit 2
    cyc(1'b1, 16'h0005, 4'h0, 1'b1);
    run_to(0, 1'b1);
    idle(24, 1'b1);
    cyc(1'b1, 16'h0005, 4'b0100, 1'b1);
    run_to(0, 1'b1);
    idle(24, 1'b1);
    idle(24, 1'b0);

    // reset during digit-2 guard with data pending
    cyc(1'b1, 16'h4321, 4'hF, 1'b0);
    run_to(16, 1'b0);
    chk("pend_before_rst", 16'(pending), 16'h1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(30, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
